// File: rtl/md5_axi4lite_slave_regs_if.sv
// rtl/md5_axi4lite_slave_regs_if.sv - AXI4-lite bus bundle between the CPU master and the MD5 register block
// Purpose: groups the five AXI4-lite channels (AW, W, B, AR, R) into one port.
// Signals: awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready,
//          araddr/arvalid/arready, rdata/rresp/rvalid/rready.
// Modports: master (drives addresses, data, ready for responses), slave (the register block).
interface md5_axi4lite_slave_regs_if #(
   parameter int AW = 32
);
   logic [AW-1:0] awaddr;
   logic          awvalid;
   logic          awready;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          wvalid;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;
   logic [AW-1:0] araddr;
   logic          arvalid;
   logic          arready;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready;

   modport master (
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  awaddr, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/md5_axi4lite_slave_regs.sv
// rtl/md5_axi4lite_slave_regs.sv - AXI4-lite register front-end for the MD5 hash core
// Purpose: holds the 512-bit message block, issues start/reset pulses to the core and
//          returns digest and status over an AXI4-lite slave port.
// Optional feature macro: MD5_DONE_IRQ_EN (adds irq_o and the IRQ register at 0x08).
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   s_axi             AXI4-lite slave modport (AW/W/B/AR/R channels)
//   msg_o             message block, MSG0 in [511:480] .. MSG15 in [31:0]
//   msg_valid_o       one-cycle start pulse to the core
//   core_rst_o        one-cycle core reset pulse
//   core_ready_i      core idle and able to accept a block
//   hash_i            digest, HASH0 in [127:96] .. HASH3 in [31:0]
//   hash_valid_i      digest valid level
//   irq_o             (MD5_DONE_IRQ_EN only) PEND & IE, registered
// Map: 0x00 CTRL WO | 0x04 STATUS RO | 0x08 IRQ RW (optional) | 0x10-0x4C MSG0-15 RW | 0x50-0x5C HASH0-3 RO
module md5_axi4lite_slave_regs #(
   parameter int AW         = 32,
   parameter int MSG_WORDS  = 16,
   parameter int HASH_WORDS = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   md5_axi4lite_slave_regs_if.slave  s_axi,
   output logic [32*MSG_WORDS-1:0]   msg_o,
   output logic                      msg_valid_o,
   output logic                      core_rst_o,
   input  logic                      core_ready_i,
   input  logic [32*HASH_WORDS-1:0]  hash_i,
   input  logic                      hash_valid_i
`ifdef MD5_DONE_IRQ_EN
   ,
   output logic                      irq_o
`endif
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   typedef enum logic [2:0] {A_CTRL, A_STATUS, A_IRQ, A_MSG, A_HASH, A_BAD} area_t;

   // Only addr[7:2] selects a register; anything above bit 7 must be zero.
   function automatic area_t decode(input logic [AW-1:0] addr);
      logic [5:0] idx;
      idx = addr[7:2];
      if (addr[AW-1:8] != '0) return A_BAD;
      if (idx == 6'd0) return A_CTRL;
      if (idx == 6'd1) return A_STATUS;
`ifdef MD5_DONE_IRQ_EN
      if (idx == 6'd2) return A_IRQ;
`endif
      if (idx >= 6'd4 && idx <= 6'd19) return A_MSG;
      if (idx >= 6'd20 && idx <= 6'd23) return A_HASH;
      return A_BAD;
   endfunction

   w_state_t      w_state;
   r_state_t      r_state;
   logic          aw_held;
   logic          w_held;
   logic [AW-1:0] aw_addr_q;
   logic [31:0]   w_data_q;
   logic [3:0]    w_strb_q;
   logic          bvalid_q;
   logic [1:0]    bresp_q;
   logic          rvalid_q;
   logic [1:0]    rresp_q;
   logic [31:0]   rdata_q;
   logic [31:0]   msg [MSG_WORDS];
   logic [31:0]   hash_w [HASH_WORDS];
   logic [31:0]   rd_data;
   logic [1:0]    rd_resp;
   logic          commit;
   area_t         wr_area;
   // MSG index wraps modulo 16, so (addr[5:2] - 4) maps 0x10..0x4C onto 0..15.
   logic [3:0]    wr_idx;
   logic [3:0]    rd_idx;

   assign commit  = (w_state == W_IDLE) && aw_held && w_held;
   assign wr_area = decode(aw_addr_q);
   assign wr_idx  = aw_addr_q[5:2] - 4'd4;
   assign rd_idx  = s_axi.araddr[5:2] - 4'd4;

   assign s_axi.awready = (w_state == W_IDLE) && !aw_held;
   assign s_axi.wready  = (w_state == W_IDLE) && !w_held;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = (r_state == R_IDLE);
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;

   always_comb begin
      msg_o = '0;
      for (int k = 0; k < MSG_WORDS; k++) msg_o[32*(MSG_WORDS-1-k) +: 32] = msg[k];
      for (int k = 0; k < HASH_WORDS; k++) hash_w[k] = hash_i[32*(HASH_WORDS-1-k) +: 32];
   end

`ifdef MD5_DONE_IRQ_EN
   logic irq_pend;
   logic irq_ie;
   logic hash_valid_q;
   logic irq_wr;

   assign irq_wr = commit && (wr_area == A_IRQ) && w_strb_q[0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_pend     <= 1'b0;
         irq_ie       <= 1'b0;
         hash_valid_q <= 1'b0;
         irq_o        <= 1'b0;
      end else begin
         hash_valid_q <= hash_valid_i;
         irq_o        <= irq_pend & irq_ie;
         if (irq_wr) begin
            irq_ie <= w_data_q[1];
            if (w_data_q[0]) irq_pend <= 1'b0;
         end
         // Last assignment wins: a new digest edge beats a same-cycle clear.
         if (hash_valid_i && !hash_valid_q) irq_pend <= 1'b1;
      end
   end
`endif

   // Write channel: AW and W are captured independently, committed together one edge later.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state     <= W_IDLE;
         aw_held     <= 1'b0;
         w_held      <= 1'b0;
         aw_addr_q   <= '0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         bvalid_q    <= 1'b0;
         bresp_q     <= RESP_OKAY;
         msg_valid_o <= 1'b0;
         core_rst_o  <= 1'b0;
         for (int k = 0; k < MSG_WORDS; k++) msg[k] <= '0;
      end else begin
         msg_valid_o <= 1'b0;
         core_rst_o  <= 1'b0;
         case (w_state)
            W_IDLE: begin
               if (s_axi.awvalid && !aw_held) begin
                  aw_held   <= 1'b1;
                  aw_addr_q <= s_axi.awaddr;
               end
               if (s_axi.wvalid && !w_held) begin
                  w_held   <= 1'b1;
                  w_data_q <= s_axi.wdata;
                  w_strb_q <= s_axi.wstrb;
               end
               if (commit) begin
                  aw_held  <= 1'b0;
                  w_held   <= 1'b0;
                  bvalid_q <= 1'b1;
                  bresp_q  <= RESP_OKAY;
                  w_state  <= W_RESP;
                  case (wr_area)
                     A_CTRL: begin
                        if (w_strb_q[0]) begin
                           // RST takes priority and suppresses START in the same write.
                           if (w_data_q[1]) begin
                              core_rst_o <= 1'b1;
                           end else if (w_data_q[0]) begin
                              if (core_ready_i) msg_valid_o <= 1'b1;
                              else              bresp_q     <= RESP_SLVERR;
                           end
                        end
                     end
                     A_MSG: begin
                        for (int b = 0; b < 4; b++)
                           if (w_strb_q[b]) msg[wr_idx][8*b +: 8] <= w_data_q[8*b +: 8];
                     end
`ifdef MD5_DONE_IRQ_EN
                     A_IRQ: bresp_q <= RESP_OKAY;
`endif
                     default: bresp_q <= RESP_SLVERR;
                  endcase
               end
            end
            W_RESP: begin
               if (s_axi.bready) begin
                  bvalid_q <= 1'b0;
                  w_state  <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read data is taken from the current register contents, so a same-edge write
   // commit to the same MSG word is not yet visible.
   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (decode(s_axi.araddr))
         A_CTRL:   rd_data = '0;
         A_STATUS: rd_data = {30'd0, hash_valid_i, core_ready_i};
`ifdef MD5_DONE_IRQ_EN
         A_IRQ:    rd_data = {30'd0, irq_ie, irq_pend};
`endif
         A_MSG:    rd_data = msg[rd_idx];
         A_HASH:   rd_data = hash_w[s_axi.araddr[3:2]];
         default:  rd_resp = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= R_IDLE;
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (s_axi.arvalid) begin
                  rdata_q  <= rd_data;
                  rresp_q  <= rd_resp;
                  rvalid_q <= 1'b1;
                  r_state  <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi.rready) begin
                  rvalid_q <= 1'b0;
                  r_state  <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md5_axi4lite_slave_regs.sv
// tb/tb_md5_axi4lite_slave_regs.sv - self-checking bench for the MD5 AXI4-lite register front-end
module tb_md5_axi4lite_slave_regs;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [511:0] msg;
   logic         msg_valid;
   logic         core_rst;
   logic         core_ready = 1'b1;
   logic [127:0] hash = '0;
   logic         hash_valid = 1'b0;
`ifdef MD5_DONE_IRQ_EN
   logic         irq;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int mv_cnt   = 0;
   int rst_cnt  = 0;

   logic [1:0]  bq[$];
   logic [33:0] rq[$];
   logic [31:0] exp_msg [16];

   md5_axi4lite_slave_regs_if #(.AW(32)) bus ();

   md5_axi4lite_slave_regs dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .s_axi        (bus),
      .msg_o        (msg),
      .msg_valid_o  (msg_valid),
      .core_rst_o   (core_rst),
      .core_ready_i (core_ready),
      .hash_i       (hash),
      .hash_valid_i (hash_valid)
`ifdef MD5_DONE_IRQ_EN
      ,
      .irq_o        (irq)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (msg_valid) mv_cnt++;
      if (core_rst) rst_cnt++;
   end

   function automatic logic [511:0] packed_msg();
      logic [511:0] p;
      for (int k = 0; k < 16; k++) p[511-32*k -: 32] = exp_msg[k];
      return p;
   endfunction

   task automatic model_msg(input int idx, input logic [31:0] data, input logic [3:0] strb);
      for (int b = 0; b < 4; b++) if (strb[b]) exp_msg[idx][8*b +: 8] = data[8*b +: 8];
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input int aw_dly, input int w_dly, input int stall);
      logic aw_done, w_done, aw_fire, w_fire;
      logic [1:0] exp;
      int t;
      aw_done = 1'b0; w_done = 1'b0;
      bq.push_back(exp_resp);
      bus.bready = (stall == 0);
      bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
      for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
         if (c == aw_dly) bus.awvalid = 1'b1;
         if (c == w_dly)  bus.wvalid  = 1'b1;
         @(negedge clk);
         aw_fire = bus.awvalid && bus.awready;
         w_fire  = bus.wvalid && bus.wready;
         @(posedge clk); #1;
         if (aw_fire) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
         if (w_fire)  begin bus.wvalid  = 1'b0; w_done  = 1'b1; end
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      t = 0;
      if (aw_done && w_done) begin
         @(negedge clk);
         while (!bus.bvalid && t < 20) begin @(negedge clk); t++; end
      end
      exp = bq.pop_front();
      n_checks++;
      if (!bus.bvalid || t != 1 || bus.bresp !== exp) begin
         n_fail++;
         $display("FAIL write_resp addr=%h: bvalid=%b latency=%0d bresp=%b, required bvalid=1 latency=1 bresp=%b",
                  addr, bus.bvalid, t, bus.bresp, exp);
      end
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.bvalid !== 1'b1 || bus.bresp !== exp || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_stall addr=%h cycle=%0d: bvalid=%b bresp=%b awready=%b wready=%b, required 1 %b 0 0",
                     addr, i, bus.bvalid, bus.bresp, bus.awready, bus.wready, exp);
         end
      end
      bus.bready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input int stall);
      logic fire;
      logic [33:0] exp;
      int t;
      fire = 1'b0;
      rq.push_back({exp_resp, exp_data});
      bus.rready = (stall == 0);
      bus.araddr = addr; bus.arvalid = 1'b1;
      for (int c = 0; c < 20 && !fire; c++) begin
         @(negedge clk);
         fire = bus.arready;
         @(posedge clk); #1;
      end
      bus.arvalid = 1'b0;
      @(negedge clk);
      t = 0;
      while (fire && !bus.rvalid && t < 20) begin @(negedge clk); t++; end
      exp = rq.pop_front();
      n_checks++;
      if (!fire || !bus.rvalid || t != 0 || bus.rdata !== exp[31:0] || bus.rresp !== exp[33:32]) begin
         n_fail++;
         $display("FAIL read addr=%h: rvalid=%b extra_wait=%0d rdata=%h rresp=%b, required rvalid=1 extra_wait=0 rdata=%h rresp=%b",
                  addr, bus.rvalid, t, bus.rdata, bus.rresp, exp[31:0], exp[33:32]);
      end
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.rvalid !== 1'b1 || bus.rdata !== exp[31:0] || bus.rresp !== exp[33:32] || bus.arready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_stall addr=%h cycle=%0d: rvalid=%b rdata=%h rresp=%b arready=%b, required 1 %h %b 0",
                     addr, i, bus.rvalid, bus.rdata, bus.rresp, bus.arready, exp[31:0], exp[33:32]);
         end
      end
      bus.rready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.bvalid, bus.rvalid, msg_valid, core_rst, bus.bresp, bus.rresp} !== 8'b0 ||
          bus.rdata !== 32'h0 || msg !== 512'h0) begin
         n_fail++;
         $display("FAIL reset_state: bvalid=%b rvalid=%b msg_valid=%b core_rst=%b bresp=%b rresp=%b rdata=%h msg_nonzero=%b, required all 0",
                  bus.bvalid, bus.rvalid, msg_valid, core_rst, bus.bresp, bus.rresp, bus.rdata, |msg);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
         n_fail++;
         $display("FAIL reset_ready: awready/wready/arready=%b, required 111", {bus.awready, bus.wready, bus.arready});
      end
      @(posedge clk); #1;
      axi_read(32'h04, 32'h1, 2'b00, 0);
   endtask

   task automatic test_msg_write();
      axi_write(32'h10, 32'h6180_0000, 4'hF, 2'b00, 2, 0, 0);
      model_msg(0, 32'h6180_0000, 4'hF);
      axi_read(32'h10, 32'h6180_0000, 2'b00, 0);
      axi_write(32'h10, 32'hFFFF_FFFF, 4'b0001, 2'b00, 0, 1, 0);
      model_msg(0, 32'hFFFF_FFFF, 4'b0001);
      axi_read(32'h10, 32'h6180_00FF, 2'b00, 0);
      n_checks++;
      if (msg[511:480] !== 32'h6180_00FF) begin
         n_fail++;
         $display("FAIL msg0_out: msg[511:480]=%h, required 618000ff", msg[511:480]);
      end
      axi_write(32'h4C, 32'h1234_5678, 4'hF, 2'b00, 0, 0, 0);
      model_msg(15, 32'h1234_5678, 4'hF);
      axi_write(32'h2A, 32'hCAFE_0000, 4'b1100, 2'b00, 0, 0, 0);
      model_msg(6, 32'hCAFE_0000, 4'b1100);
      axi_read(32'h4C, 32'h1234_5678, 2'b00, 0);
      n_checks++;
      if (msg !== packed_msg()) begin
         n_fail++;
         $display("FAIL msg_block: msg=%h, required %h", msg, packed_msg());
      end
   endtask

   task automatic test_start();
      int mv0;
      for (int k = 0; k < 16; k++) begin
         axi_write(32'h10 + 4*k, (k == 0) ? 32'h8000_0000 : 32'h0, 4'hF, 2'b00, 0, 0, 0);
         model_msg(k, (k == 0) ? 32'h8000_0000 : 32'h0, 4'hF);
      end
      n_checks++;
      if (msg !== packed_msg()) begin
         n_fail++;
         $display("FAIL empty_block: msg=%h, required %h", msg, packed_msg());
      end
      mv0 = mv_cnt;
      axi_write(32'h00, 32'h1, 4'hF, 2'b00, 0, 0, 0);
      repeat (4) @(posedge clk); #1;
      n_checks++;
      if (mv_cnt - mv0 !== 1) begin
         n_fail++;
         $display("FAIL start_pulse: msg_valid high cycles=%0d, required 1", mv_cnt - mv0);
      end
      hash = 128'hd41d8cd98f00b204e9800998ecf8427e;
      hash_valid = 1'b1;
      @(posedge clk); #1;
      axi_read(32'h50, 32'hd41d8cd9, 2'b00, 0);
      axi_read(32'h54, 32'h8f00b204, 2'b00, 0);
      axi_read(32'h58, 32'he9800998, 2'b00, 0);
      axi_read(32'h5C, 32'hecf8427e, 2'b00, 0);
      axi_read(32'h04, 32'h3, 2'b00, 0);
   endtask

   task automatic test_ctrl_errors();
      int mv0, rs0;
      mv0 = mv_cnt; rs0 = rst_cnt;
      core_ready = 1'b0;
      axi_write(32'h00, 32'h1, 4'hF, 2'b10, 0, 0, 0);
      axi_read(32'h04, 32'h2, 2'b00, 0);
      core_ready = 1'b1;
      axi_write(32'h00, 32'h3, 4'hF, 2'b00, 0, 0, 0);
      axi_write(32'h00, 32'h3, 4'hE, 2'b00, 0, 0, 0);
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if (mv_cnt - mv0 !== 0 || rst_cnt - rs0 !== 1 || msg !== packed_msg()) begin
         n_fail++;
         $display("FAIL ctrl_pulses: msg_valid cycles=%0d core_rst cycles=%0d msg_kept=%b, required 0 1 1",
                  mv_cnt - mv0, rst_cnt - rs0, msg === packed_msg());
      end
   endtask

   task automatic test_errors();
      axi_write(32'h80, 32'hDEAD_BEEF, 4'hF, 2'b10, 0, 0, 0);
      axi_write(32'h50, 32'hDEAD_BEEF, 4'hF, 2'b10, 0, 0, 0);
      axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, 2'b10, 0, 0, 0);
      axi_write(32'h110, 32'hDEAD_BEEF, 4'hF, 2'b10, 1, 0, 0);
      axi_read(32'hFC, 32'h0, 2'b10, 0);
      axi_read(32'h110, 32'h0, 2'b10, 0);
`ifndef MD5_DONE_IRQ_EN
      axi_write(32'h08, 32'h3, 4'hF, 2'b10, 0, 0, 0);
      axi_read(32'h08, 32'h0, 2'b10, 0);
`endif
      axi_read(32'h50, 32'hd41d8cd9, 2'b00, 0);
      n_checks++;
      if (msg !== packed_msg()) begin
         n_fail++;
         $display("FAIL error_no_effect: msg=%h, required %h", msg, packed_msg());
      end
      axi_write(32'h80, 32'h0, 4'hF, 2'b10, 0, 0, 5);
      axi_write(32'h18, 32'hA5A5_5A5A, 4'hF, 2'b00, 0, 0, 5);
      model_msg(2, 32'hA5A5_5A5A, 4'hF);
      axi_read(32'h18, 32'hA5A5_5A5A, 2'b00, 5);
      axi_read(32'hFC, 32'h0, 2'b10, 5);
   endtask

   task automatic test_reset_mid();
      int t;
      hash_valid = 1'b0;
      bus.bready = 1'b0;
      bus.awaddr = 32'h1C; bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      model_msg(3, 32'h0BAD_F00D, 4'hF);
      t = 0;
      @(negedge clk);
      while (!bus.bvalid && t < 10) begin @(negedge clk); t++; end
      n_checks++;
      if (bus.bvalid !== 1'b1 || msg !== packed_msg()) begin
         n_fail++;
         $display("FAIL pre_reset: bvalid=%b msg_match=%b, required 1 1", bus.bvalid, msg === packed_msg());
      end
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (bus.bvalid !== 1'b0 || msg !== 512'h0) begin
         n_fail++;
         $display("FAIL mid_reset: bvalid=%b msg_nonzero=%b, required 0 0", bus.bvalid, |msg);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.bready = 1'b1;
      for (int k = 0; k < 16; k++) exp_msg[k] = '0;
      axi_read(32'h1C, 32'h0, 2'b00, 0);
`ifdef MD5_DONE_IRQ_EN
      axi_write(32'h08, 32'h2, 4'h1, 2'b00, 0, 0, 0);
      hash_valid = 1'b1;
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_set: irq_o=%b, required 1", irq);
      end
      axi_read(32'h08, 32'h3, 2'b00, 0);
      axi_write(32'h08, 32'h3, 4'h1, 2'b00, 0, 0, 0);
      repeat (2) @(posedge clk); #1;
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_clear: irq_o=%b, required 0", irq);
      end
      axi_read(32'h08, 32'h2, 2'b00, 0);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.awaddr = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b1;
      bus.araddr = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      for (int k = 0; k < 16; k++) exp_msg[k] = '0;
      test_reset();
      test_msg_write();
      test_start();
      test_ctrl_errors();
      test_errors();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
